// File: rtl/fsm_state_monitor.sv
// Runtime monitor for a DUT FSM's encoded state stream: legality check against a
// programmable transition table, per-state visit counts and unreached-state report.
module fsm_state_monitor #(
    parameter int STATE_W = 2,
    parameter int CNT_W   = 8,
    parameter int WINDOW  = 64
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 state_valid,
    input  logic [STATE_W-1:0]                   state_in,
    input  logic [(1<<(2*STATE_W))-1:0]          legal_mask,
    input  logic [(1<<STATE_W)-1:0]              reach_mask,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 illegal_trans,
    output logic [STATE_W-1:0]                   illegal_from,
    output logic [STATE_W-1:0]                   illegal_to,
    output logic [CNT_W-1:0]                     err_count,
    output logic [(1<<STATE_W)-1:0]              unreached,
    output logic [(1<<STATE_W)*CNT_W-1:0]        visit_cnt
);

    localparam int N     = 1 << STATE_W;
    localparam int SMP_W = $clog2(WINDOW + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FIRST = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [SMP_W-1:0] SMP_ONE  = SMP_W'(1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(WINDOW - 1);

    logic [1:0]         state;
    logic [STATE_W-1:0] prev;
    logic [N-1:0]       visited;
    logic [SMP_W-1:0]   samples;
    logic [CNT_W-1:0]   cnt [N];

    logic [N-1:0]       in_onehot;
    logic [N-1:0]       visited_nxt;
    logic [CNT_W-1:0]   cnt_inc;
    logic               is_legal;

    always_comb begin
        in_onehot           = '0;
        in_onehot[state_in] = 1'b1;
        visited_nxt         = visited | in_onehot;
        cnt_inc             = (cnt[state_in] == CNT_MAX) ? CNT_MAX : cnt[state_in] + CNT_ONE;
        is_legal            = legal_mask[{prev, state_in}];
    end

    assign busy = (state == S_FIRST) || (state == S_RUN);

    for (genvar s = 0; s < N; s++) begin : g_visit
        assign visit_cnt[s*CNT_W +: CNT_W] = cnt[s];
    end

    // done and unreached are registered on the edge that accepts the final sample,
    // so both are visible together during the one-cycle DONE state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            prev          <= '0;
            visited       <= '0;
            samples       <= '0;
            done          <= 1'b0;
            illegal_trans <= 1'b0;
            illegal_from  <= '0;
            illegal_to    <= '0;
            err_count     <= '0;
            unreached     <= '0;
            for (int s = 0; s < N; s++) cnt[s] <= '0;
        end else begin
            done          <= 1'b0;
            illegal_trans <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_FIRST;
                        visited      <= '0;
                        samples      <= '0;
                        err_count    <= '0;
                        illegal_from <= '0;
                        illegal_to   <= '0;
                        unreached    <= '0;
                        for (int s = 0; s < N; s++) cnt[s] <= '0;
                    end
                end
                S_FIRST: begin
                    if (state_valid) begin
                        prev           <= state_in;
                        visited        <= visited_nxt;
                        cnt[state_in]  <= cnt_inc;
                        samples        <= SMP_ONE;
                        state          <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (state_valid) begin
                        prev          <= state_in;
                        visited       <= visited_nxt;
                        cnt[state_in] <= cnt_inc;
                        samples       <= samples + SMP_ONE;
                        if (!is_legal) begin
                            illegal_trans <= 1'b1;
                            illegal_from  <= prev;
                            illegal_to    <= state_in;
                            if (err_count != CNT_MAX) err_count <= err_count + CNT_ONE;
                        end
                        if (samples == SMP_LAST) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            unreached <= reach_mask & ~visited_nxt;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_state_monitor.sv
// Directed/random bench for fsm_state_monitor; a CNT_W=8 and a CNT_W=4 instance
// share stimulus and are checked against a window-level reference model.
module tb_fsm_state_monitor;

    localparam int WINDOW = 64;

    logic        clk = 1'b0;
    logic        rst_n, start, state_valid;
    logic [1:0]  state_in;
    logic [15:0] legal_mask;
    logic [3:0]  reach_mask;

    logic        busy_a, done_a, ill_a, busy_s, done_s, ill_s;
    logic [1:0]  from_a, to_a, from_s, to_s;
    logic [7:0]  err_a;
    logic [3:0]  err_s;
    logic [3:0]  unr_a, unr_s;
    logic [31:0] vc_a;
    logic [15:0] vc_s;

    always #5 clk = ~clk;

    fsm_state_monitor #(.STATE_W(2), .CNT_W(8), .WINDOW(WINDOW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .state_valid(state_valid),
        .state_in(state_in), .legal_mask(legal_mask), .reach_mask(reach_mask),
        .busy(busy_a), .done(done_a), .illegal_trans(ill_a), .illegal_from(from_a),
        .illegal_to(to_a), .err_count(err_a), .unreached(unr_a), .visit_cnt(vc_a)
    );

    fsm_state_monitor #(.STATE_W(2), .CNT_W(4), .WINDOW(WINDOW)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .state_valid(state_valid),
        .state_in(state_in), .legal_mask(legal_mask), .reach_mask(reach_mask),
        .busy(busy_s), .done(done_s), .illegal_trans(ill_s), .illegal_from(from_s),
        .illegal_to(to_s), .err_count(err_s), .unreached(unr_s), .visit_cnt(vc_s)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: a window is a list of accepted samples; everything else
    // follows from counting pairs and occurrences in that list.
    bit         m_active, m_in_done;
    int         m_samples, m_err;
    int         m_visits [4];
    logic [1:0] m_prev, m_from, m_to;
    logic [3:0] m_unreached;

    function automatic int sat(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_samples   = 0;
        m_err       = 0;
        m_from      = '0;
        m_to        = '0;
        m_prev      = '0;
        m_unreached = '0;
        for (int s = 0; s < 4; s++) m_visits[s] = 0;
    endtask

    task automatic check_all(input bit exp_ill, input bit exp_done);
        chk("busy_a", 32'(busy_a), 32'(m_active));
        chk("busy_s", 32'(busy_s), 32'(m_active));
        chk("done_a", 32'(done_a), 32'(exp_done));
        chk("done_s", 32'(done_s), 32'(exp_done));
        chk("illegal_a", 32'(ill_a), 32'(exp_ill));
        chk("illegal_s", 32'(ill_s), 32'(exp_ill));
        chk("from_a", 32'(from_a), 32'(m_from));
        chk("to_a", 32'(to_a), 32'(m_to));
        chk("from_s", 32'(from_s), 32'(m_from));
        chk("to_s", 32'(to_s), 32'(m_to));
        chk("err_a", 32'(err_a), sat(m_err, 8));
        chk("err_s", 32'(err_s), sat(m_err, 4));
        chk("unreached_a", 32'(unr_a), 32'(m_unreached));
        chk("unreached_s", 32'(unr_s), 32'(m_unreached));
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("visit_a[%0d]", s), 32'(vc_a[s*8 +: 8]), sat(m_visits[s], 8));
            chk($sformatf("visit_s[%0d]", s), 32'(vc_s[s*4 +: 4]), sat(m_visits[s], 4));
        end
    endtask

    // Drive one cycle of inputs, let the edge pass, update the model, check.
    task automatic step(input bit v, input logic [1:0] s, input bit st);
        bit         exp_ill, exp_done;
        logic [3:0] seen;
        start       = st;
        state_valid = v;
        state_in    = s;
        @(negedge clk);
        exp_ill  = 1'b0;
        exp_done = 1'b0;
        if (m_in_done) begin
            m_in_done = 1'b0;
        end else if (!m_active) begin
            if (st) begin
                model_clear();
                m_active = 1'b1;
            end
        end else if (v) begin
            if (m_samples > 0 && !legal_mask[int'(m_prev) * 4 + int'(s)]) begin
                exp_ill = 1'b1;
                m_err++;
                m_from = m_prev;
                m_to   = s;
            end
            m_prev = s;
            m_visits[s]++;
            m_samples++;
            if (m_samples == WINDOW) begin
                seen = '0;
                for (int k = 0; k < 4; k++) seen[k] = (m_visits[k] > 0);
                m_unreached = reach_mask & ~seen;
                exp_done    = 1'b1;
                m_active    = 1'b0;
                m_in_done   = 1'b1;
            end
        end
        check_all(exp_ill, exp_done);
        start       = 1'b0;
        state_valid = 1'b0;
    endtask

    task automatic run_random(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) step(1'b0, 2'($urandom_range(0, 3)), 1'b0);
            step(1'b1, 2'($urandom_range(0, 3)), 1'b0);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        state_valid = 1'b0;
        state_in    = '0;
        legal_mask  = 16'h0112;
        reach_mask  = 4'b0111;
        m_active    = 1'b0;
        m_in_done   = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        check_all(1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Alternating legal stream 0,1,0,1...
        step(1'b0, 2'd0, 1'b1);
        for (int i = 0; i < WINDOW; i++) step(1'b1, 2'(i % 2), 1'b0);
        chk("t1_done", 32'(done_a), 32'd1);
        chk("t1_unreached", 32'(unr_a), 32'h4);
        chk("t1_err", 32'(err_a), 32'd0);
        chk("t1_visit0", 32'(vc_a[7:0]), 32'd32);
        chk("t1_visit1", 32'(vc_a[15:8]), 32'd32);
        step(1'b0, 2'd0, 1'b1);
        step(1'b0, 2'd0, 1'b0);
        chk("t1_start_in_done_ignored", 32'(busy_a), 32'd0);

        // Illegal 1->3
        step(1'b0, 2'd0, 1'b1);
        step(1'b1, 2'd0, 1'b0);
        step(1'b1, 2'd1, 1'b0);
        step(1'b1, 2'd3, 1'b0);
        chk("t2_pulse", 32'(ill_a), 32'd1);
        chk("t2_from", 32'(from_a), 32'd1);
        chk("t2_to", 32'(to_a), 32'd3);
        chk("t2_err", 32'(err_a), 32'd1);
        run_random(WINDOW - 3, 0);
        step(1'b0, 2'd0, 1'b0);

        // Self-transition with diagonal bit clear, then set
        step(1'b0, 2'd0, 1'b1);
        step(1'b1, 2'd0, 1'b0);
        step(1'b1, 2'd0, 1'b0);
        chk("t3_diag_illegal", 32'(ill_a), 32'd1);
        run_random(WINDOW - 2, 0);
        step(1'b0, 2'd0, 1'b0);
        legal_mask = 16'h0113;
        step(1'b0, 2'd0, 1'b1);
        step(1'b1, 2'd0, 1'b0);
        step(1'b1, 2'd0, 1'b0);
        chk("t3_diag_legal", 32'(ill_a), 32'd0);
        run_random(WINDOW - 2, 0);
        step(1'b0, 2'd0, 1'b0);

        // One valid every 3 cycles
        legal_mask = 16'($urandom);
        reach_mask = 4'($urandom);
        step(1'b0, 2'd0, 1'b1);
        run_random(WINDOW, 2);
        chk("t4_done_after_samples", 32'(done_a), 32'd1);
        step(1'b0, 2'd0, 1'b0);

        // Error saturation (20 illegal 3->3) and start mid-window
        legal_mask = 16'h0112;
        reach_mask = 4'b0111;
        step(1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 21; i++) step(1'b1, 2'd3, 1'b0);
        chk("t5_err_sat", 32'(err_s), 32'd15);
        chk("t5_err_wide", 32'(err_a), 32'd20);
        run_random(10, 0);
        step(1'b1, 2'($urandom_range(0, 3)), 1'b1);
        chk("t5_start_ignored", 32'(busy_a), 32'd1);
        run_random(WINDOW - 32, 0);
        step(1'b0, 2'd0, 1'b0);

        // Reset mid-window, then a fresh full window
        step(1'b0, 2'd0, 1'b1);
        run_random(30, 0);
        rst_n = 1'b0;
        #1;
        m_active  = 1'b0;
        m_in_done = 1'b0;
        model_clear();
        check_all(1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0);
        step(1'b0, 2'd0, 1'b1);
        run_random(WINDOW, $urandom_range(0, 1));
        chk("t6_restart_done", 32'(done_a), 32'd1);
        step(1'b0, 2'd0, 1'b0);
        step(1'b0, 2'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
